// File: rtl/lifo_drain_reader.sv
// Fixed-depth LIFO with a push port and a drain engine that empties the stack top-first
// onto a valid/ready stream. Optional DRAIN_WORD_CNT_EN adds a drained_words counter.
module lifo_drain_reader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              drain_req,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    input  logic              pop_ready,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] last_value,
    output logic              drain_busy,
    output logic              drain_done,
`ifdef DRAIN_WORD_CNT_EN
    output logic [CNT_W-1:0]  drained_words,
`endif
    output logic              overflow
);

    // Handshakes: a word moves on any rising edge where valid && ready are both high.
    // pop_valid never retracts and pop_data holds stable until that edge.

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              is_idle;
    logic              full;
    logic              empty;
    logic              push_acc;
    logic              pop_fire;

    assign is_idle  = (state == IDLE);
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_idx   = IDX_W'(count);
    assign top_idx  = IDX_W'(count - CNT_W'(1));

    // Gated by reset so every output reads 0 while reset is held.
    assign push_ready = !reset && is_idle && !full;
    assign push_acc   = push_valid && push_ready;

    assign pop_valid  = (state == DRAIN) && !empty;
    assign pop_fire   = pop_valid && pop_ready;
    assign last_value = empty ? '0 : mem[top_idx];
    assign pop_data   = pop_valid ? last_value : '0;
    assign drain_busy = (state == DRAIN);
    assign drain_done = (state == DONE);

    // Storage needs no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) begin
                count <= count + CNT_W'(1);
            end else if (pop_fire) begin
                count <= count - CNT_W'(1);
            end

            if (is_idle && push_valid && full) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // A same-cycle push lands first, so it becomes the first word popped.
                    if (drain_req) begin
                        state <= (!empty || push_acc) ? DRAIN : DONE;
                    end
                end
                DRAIN: begin
                    if (pop_fire && (count == CNT_W'(1))) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DRAIN_WORD_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drained_words <= '0;
        end else if (is_idle && drain_req) begin
            drained_words <= '0;
        end else if (pop_fire) begin
            drained_words <= drained_words + CNT_W'(1);
        end
    end
`endif

endmodule
